// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised edge detector with mode-qualified pulses,
// sticky event flags, a saturating event counter and a post-reset warm-up gate.
module edge_detect_multi #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   sticky_clr,
  input  logic               cnt_clr,
  output logic [WIDTH-1:0]   pos_pulse,
  output logic [WIDTH-1:0]   neg_pulse,
  output logic [WIDTH-1:0]   edge_pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic [CNT_W-1:0]   evt_cnt,
  output logic               irq,
  output logic               ready
);

  localparam int unsigned WARM_W = 3;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WARM_W-1:0] warm_q, warm_d;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] pos_d, neg_d, edge_d, sticky_d;
  logic [CNT_W-1:0] cnt_d;
  logic             run;

  // Warm-up sequencer: SYNC_STAGES+1 cycles flushes the chain and prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      WARMUP: begin
        if (warm_q == WARM_LAST) begin
          state_d = RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = WARMUP;
    endcase
  end

  assign s_last = sync_q[SYNC_STAGES-1];
  assign run    = (state_q == RUN);

  // Pulse, sticky and counter next-state; pulses are gated off during warm-up.
  always_comb begin
    pos_d  = run ? (s_last & ~prev_q) : '0;
    neg_d  = run ? (~s_last & prev_q) : '0;
    edge_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      edge_d[i] = (mode[2*i] & pos_d[i]) | (mode[2*i+1] & neg_d[i]);
    end
    sticky_d = (sticky & ~sticky_clr) | edge_d;
    cnt_d    = evt_cnt;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((|edge_d) && (evt_cnt != CNT_MAX)) begin
      cnt_d = evt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
      prev_q     <= '0;
      pos_pulse  <= '0;
      neg_pulse  <= '0;
      edge_pulse <= '0;
      sticky     <= '0;
      evt_cnt    <= '0;
      irq        <= 1'b0;
      ready      <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q     <= s_last;
      pos_pulse  <= pos_d;
      neg_pulse  <= neg_d;
      edge_pulse <= edge_d;
      sticky     <= sticky_d;
      evt_cnt    <= cnt_d;
      irq        <= |sticky_d;
      ready      <= (state_d == RUN);
    end
  end

endmodule
